// File: rtl/fifo_serializer.sv
// Pops 32-bit words from the async FIFO's read side and shifts them out one bit at a time
// over a valid/ready link, marking the first and last bit of each word and counting words sent.
module fifo_serializer #(
  parameter int DATA_WIDTH      = 32,
  parameter int BIT_COUNT_BITS  = 5,
  parameter bit MSB_FIRST       = 1'b1,
  parameter int WORD_COUNT_BITS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DATA_WIDTH-1:0]      fifo_q,
  input  logic                       fifo_empty,
  output logic                       fifo_read_enable,
  input  logic                       serial_ready,
  output logic                       serial_valid,
  output logic                       serial_data,
  output logic                       serial_first,
  output logic                       serial_last,
  output logic                       busy,
  output logic [WORD_COUNT_BITS-1:0] words_sent
);

  // Handshake: a bit is transferred on a rising clock edge where serial_valid and
  // serial_ready are both high; while serial_ready is low, data and flags stay frozen.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] POP   = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  localparam logic [BIT_COUNT_BITS-1:0] LAST_BIT = BIT_COUNT_BITS'(DATA_WIDTH - 1);

  logic [1:0]                 state_q, state_d;
  logic [DATA_WIDTH-1:0]      shift_reg_q, shift_reg_d;
  logic [BIT_COUNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_COUNT_BITS-1:0] words_sent_q, words_sent_d;

  logic start_ok;
  logic in_shift;
  logic at_last;

  assign start_ok = enable & ~fifo_empty;
  assign in_shift = (state_q == SHIFT);
  assign at_last  = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    bit_cnt_d    = bit_cnt_q;
    words_sent_d = words_sent_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        // fifo_q becomes valid one cycle after the pop pulse, i.e. now.
        shift_reg_d = fifo_q;
        bit_cnt_d   = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (serial_ready) begin
          if (at_last) begin
            words_sent_d = words_sent_q + WORD_COUNT_BITS'(1);
            state_d      = start_ok ? POP : IDLE;
          end else begin
            shift_reg_d = MSB_FIRST ? (shift_reg_q << 1) : (shift_reg_q >> 1);
            bit_cnt_d   = bit_cnt_q + BIT_COUNT_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_reg_q  <= '0;
      bit_cnt_q    <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      bit_cnt_q    <= bit_cnt_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign fifo_read_enable = (state_q == POP);
  assign busy             = (state_q != IDLE);
  assign serial_valid     = in_shift;
  assign serial_data      = in_shift & (MSB_FIRST ? shift_reg_q[DATA_WIDTH-1] : shift_reg_q[0]);
  assign serial_first     = in_shift & (bit_cnt_q == '0);
  assign serial_last      = in_shift & at_last;
  assign words_sent       = words_sent_q;

endmodule
